// File: rtl/gate_test_sequencer.sv
// Clocked stimulus/check controller for an N-input, single-output logic gate.
// Walks every input vector, samples the gate in the last hold cycle, and compares against a latched truth table.
module gate_test_sequencer #(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   truth_tbl,
    input  logic                 gate_y,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail_vec
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
    localparam logic [N_IN:0]   FAIL_ONE  = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [2**N_IN-1:0]  tbl_q;
    logic [HW-1:0]       hold_cnt;
    logic                mismatch;

    assign mismatch = (gate_y != tbl_q[vec_out]);

    // pass is resolved on the final-sample edge so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tbl_q          <= '0;
            hold_cnt       <= '0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vec_out <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        tbl_q          <= truth_tbl;
                        fail_count     <= '0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        hold_cnt       <= '0;
                        busy           <= 1'b1;
                        state          <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        vec_out <= '0;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                        state   <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (mismatch) begin
                            fail_count <= fail_count + FAIL_ONE;
                            if (fail_count == '0) begin
                                first_fail_vec <= vec_out;
                            end
                        end
                        if (vec_out == VEC_LAST) begin
                            vec_out <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (fail_count == '0) && !mismatch;
                            state   <= DONE;
                        end else begin
                            vec_out <= vec_out + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    vec_out <= '0;
                    state   <= IDLE;
                end

                default: begin
                    vec_out <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer (N_IN=2, HOLD_CYCLES=4) with a modelled gate under control.
module tb_gate_test_sequencer;

    localparam int N_IN = 2;
    localparam int H    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  truth_tbl;
    logic        gate_y;
    logic [1:0]  vec_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_count;
    logic [1:0]  first_fail_vec;

    int checkCount = 0;
    int passCount  = 0;
    int gate_mode  = 0;
    int gate_delay = 0;
    int cycles;
    int guard;
    int sawDone;

    logic [1:0] hist [0:7];
    logic [1:0] gate_src;

    gate_test_sequencer #(.N_IN(N_IN), .HOLD_CYCLES(H)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .truth_tbl      (truth_tbl),
        .gate_y         (gate_y),
        .vec_out        (vec_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;

    // hist[d-1] is vec_out as it was d clocks ago, giving a gate with d cycles of latency.
    always @(posedge clk) begin
        hist[0] <= vec_out;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        gate_src = (gate_delay == 0) ? vec_out : hist[gate_delay-1];
        gate_y   = 1'b0;
        case (gate_mode)
            0: gate_y = &gate_src;
            1: gate_y = 1'b0;
            2: gate_y = |gate_src;
            default: gate_y = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Start a run at the next edge and count clocks until done; truth_tbl switches to tblLate 5 clocks in.
    task automatic applyStimulus(input logic [3:0] tbl, input logic [3:0] tblLate,
                                 input int mode, input int dly, output int nCycles);
        gate_mode  = mode;
        gate_delay = dly;
        truth_tbl  = tbl;
        start      = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        nCycles = 0;
        while (done !== 1'b1 && nCycles < 100) begin
            @(posedge clk); #1;
            nCycles++;
            if (nCycles == 5) truth_tbl = tblLate;
        end
    endtask

    task automatic waitVec(input logic [1:0] v);
        guard = 0;
        while (vec_out !== v && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("wait_vec_reached", int'(vec_out), int'(v));
    endtask

    task automatic checkResult(input string tag, input int expPass, input int expFails, input int expFirst);
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, int'(done), 0);
        checkOutput({tag, "_pass"}, int'(pass), expPass);
        checkOutput({tag, "_fail_count"}, int'(fail_count), expFails);
        if (expFails != 0) checkOutput({tag, "_first_fail"}, int'(first_fail_vec), expFirst);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        truth_tbl = 4'b0000;
        #1;
        checkOutput("rst_vec_out", int'(vec_out), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_pass", int'(pass), 0);
        checkOutput("rst_fail_count", int'(fail_count), 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // AND gate, matching table
        applyStimulus(4'b1000, 4'b1000, 0, 0, cycles);
        checkOutput("and_latency", cycles, 16);
        checkOutput("and_done", int'(done), 1);
        checkOutput("and_busy_at_done", int'(busy), 0);
        checkResult("and", 1, 0, 0);

        // gate stuck at 0
        applyStimulus(4'b1000, 4'b1000, 1, 0, cycles);
        checkOutput("zero_latency", cycles, 16);
        checkResult("zero", 0, 1, 3);

        // OR gate against an AND table
        applyStimulus(4'b1000, 4'b1000, 2, 0, cycles);
        checkOutput("or_latency", cycles, 16);
        checkResult("or", 0, 2, 1);

        // gate latency H-1 still settles before the sample
        applyStimulus(4'b1000, 4'b1000, 0, H-1, cycles);
        checkResult("delay3", 1, 0, 0);

        // gate latency H shows the previous vector at each sample
        applyStimulus(4'b1000, 4'b1000, 0, H, cycles);
        checkResult("delay4", 0, 1, 3);

        // table change mid-run is ignored
        applyStimulus(4'b1000, 4'b0111, 0, 0, cycles);
        checkResult("tbl_change", 1, 0, 0);

        // abort while vec_out=2; vec0 already mismatched
        gate_mode = 1;
        truth_tbl = 4'b0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("abort_busy_running", int'(busy), 1);
        waitVec(2'd2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_vec_out", int'(vec_out), 0);
        checkOutput("abort_pass", int'(pass), 0);
        checkOutput("abort_fail_count", int'(fail_count), 1);
        checkOutput("abort_first_fail", int'(first_fail_vec), 0);
        sawDone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) sawDone = 1;
        end
        checkOutput("abort_no_done", sawDone, 0);

        // abort on the same edge as the final sample
        gate_mode = 0;
        truth_tbl = 4'b1000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitVec(2'd3);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_last_done", int'(done), 0);
        checkOutput("abort_last_busy", int'(busy), 0);
        @(posedge clk); #1;
        checkOutput("abort_last_done_after", int'(done), 0);
        checkOutput("abort_last_pass", int'(pass), 0);

        // async reset between edges mid-run
        gate_mode = 1;
        truth_tbl = 4'b1111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitVec(2'd2);
        checkOutput("pre_rst_fail_count", int'(fail_count), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_vec_out", int'(vec_out), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_fail_count", int'(fail_count), 0);
        checkOutput("midrst_first_fail", int'(first_fail_vec), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sawDone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1 || vec_out !== 2'd0) sawDone = 1;
        end
        checkOutput("post_rst_idle", sawDone, 0);

        // fresh run after reset still works
        applyStimulus(4'b1000, 4'b1000, 0, 0, cycles);
        checkOutput("post_rst_latency", cycles, 16);
        checkResult("post_rst", 1, 0, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
